// File: rtl/ripple_count_monitor_pkg.sv
// ripple_mon_pkg -- shared types and default widths for the ripple count monitor.
//   mon_state_e   : monitor FSM states
//   step_class_e  : classification of a stable count step
//   classify_step : maps step predicates onto a step class
package ripple_mon_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic {
        MON_INIT  = 1'b0,
        MON_TRACK = 1'b1
    } mon_state_e;

    typedef enum logic [1:0] {
        STEP_NORMAL  = 2'd0,
        STEP_WRAP    = 2'd1,
        STEP_RESTART = 2'd2,
        STEP_OTHER   = 2'd3
    } step_class_e;

    // A step into zero is a wrap only when coming from the top value; any
    // other arrival at zero means the upstream counter was restarted.
    function automatic step_class_e classify_step(input logic p_is_max,
                                                  input logic v_is_zero,
                                                  input logic v_is_incr);
        if (v_is_zero)
            return p_is_max ? STEP_WRAP : STEP_RESTART;
        else if (v_is_incr)
            return STEP_NORMAL;
        else
            return STEP_OTHER;
    endfunction

endpackage

// File: rtl/ripple_count_monitor_if.sv
// ripple_count_monitor_if -- wrap event valid/ready channel.
//   evt_valid : wrap event pending (monitor -> consumer)
//   evt_value : wrap_count snapshot of the pending event (monitor -> consumer)
//   evt_ready : consumer accepts the event (consumer -> monitor)
// master = monitor side, slave = consumer side.
interface ripple_count_monitor_if
    import ripple_mon_pkg::*;
#(
    parameter int WRAP_W = DEF_WRAP_W
);
    logic              evt_valid;
    logic [WRAP_W-1:0] evt_value;
    logic              evt_ready;

    modport master (output evt_valid, output evt_value, input evt_ready);
    modport slave  (input evt_valid, input evt_value, output evt_ready);
endinterface

// File: rtl/ripple_count_monitor_q_sync_filter.sv
// q_sync_filter -- two-stage sampler of the ripple count with settle detection.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   q      : raw ripple counter output (may glitch)
//   stable : two consecutive samples agree
//   value  : older of the two samples (valid as a count when stable)
module q_sync_filter
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    output logic             stable,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= q;
            s2 <= s1;
        end
    end

    assign stable = (s1 == s2);
    assign value  = s2;
endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor -- filters the ripple count, tracks wraps and restarts,
// and offers each wrap as a one-entry valid/ready event.
//   clk        : system clock
//   reset      : asynchronous, active-high; clears everything
//   q          : ripple counter output
//   cnt_stable : last filtered count
//   wrap_count : wraps since reset or last restart (modulo 2^WRAP_W)
//   evt        : event channel (master): evt_valid / evt_value / evt_ready
//   evt_ovf    : sticky, a wrap event was dropped
//   err        : sticky step-error flag, only when RIPPLE_MON_ERR_EN is defined
//
// state     | meaning
// MON_INIT  | waiting for first stable sample to use as baseline
// MON_TRACK | classifying every stable step
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  cnt_stable,
    output logic [WRAP_W-1:0] wrap_count,
    ripple_count_monitor_if.master evt,
    output logic              evt_ovf
`ifdef RIPPLE_MON_ERR_EN
    ,
    output logic              err
`endif
);
    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic              stable;
    logic [WIDTH-1:0]  value;
    mon_state_e        state;
    mon_state_e        state_next;
    step_class_e       cls;
    logic              do_load;
    logic              do_wrap;
    logic              do_restart;
    logic [WRAP_W-1:0] wrap_next;
    logic              evt_valid_r;
    logic [WRAP_W-1:0] evt_value_r;
`ifdef RIPPLE_MON_ERR_EN
    logic              do_other;
`endif

    q_sync_filter #(.WIDTH(WIDTH)) u_filter (
        .clk    (clk),
        .reset  (reset),
        .q      (q),
        .stable (stable),
        .value  (value)
    );

    assign cls       = classify_step(cnt_stable == CNT_MAX,
                                     value == '0,
                                     value == cnt_stable + CNT_ONE);
    assign wrap_next = wrap_count + WRAP_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= MON_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MON_INIT:  if (stable) state_next = MON_TRACK;
            MON_TRACK: state_next = MON_TRACK;
            default:   state_next = MON_INIT;
        endcase
    end

    always_comb begin
        do_load    = 1'b0;
        do_wrap    = 1'b0;
        do_restart = 1'b0;
`ifdef RIPPLE_MON_ERR_EN
        do_other   = 1'b0;
`endif
        case (state)
            // Baseline load happens even when the value matches cnt_stable.
            MON_INIT: do_load = stable;
            MON_TRACK: begin
                if (stable && (value != cnt_stable)) begin
                    do_load = 1'b1;
                    case (cls)
                        STEP_WRAP:    do_wrap    = 1'b1;
                        STEP_RESTART: do_restart = 1'b1;
`ifdef RIPPLE_MON_ERR_EN
                        STEP_OTHER:   do_other   = 1'b1;
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_stable  <= '0;
            wrap_count  <= '0;
            evt_valid_r <= 1'b0;
            evt_value_r <= '0;
            evt_ovf     <= 1'b0;
        end else begin
            if (do_load)
                cnt_stable <= value;

            if (do_restart)
                wrap_count <= '0;
            else if (do_wrap)
                wrap_count <= wrap_next;

            // A wrap landing on an accept cycle refills the slot directly.
            if (do_wrap) begin
                if (!evt_valid_r || evt.evt_ready) begin
                    evt_valid_r <= 1'b1;
                    evt_value_r <= wrap_next;
                end else begin
                    evt_ovf <= 1'b1;
                end
            end else if (evt_valid_r && evt.evt_ready) begin
                evt_valid_r <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = evt_valid_r;
    assign evt.evt_value = evt_value_r;

`ifdef RIPPLE_MON_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (do_other)
            err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: an abstract per-cycle model compared on
// every falling edge, plus directed scenarios with hand-computed literals.
// Honours RIPPLE_MON_ERR_EN for the err port.
module tb_ripple_count_monitor;
    import ripple_mon_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic [3:0] cnt_stable;
    logic [7:0] wrap_count;
    logic       evt_ovf;
`ifdef RIPPLE_MON_ERR_EN
    logic       err;
`endif

    ripple_count_monitor_if #(.WRAP_W(8)) evt_if ();

    ripple_count_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .q          (q),
        .cnt_stable (cnt_stable),
        .wrap_count (wrap_count),
        .evt        (evt_if),
        .evt_ovf    (evt_ovf)
`ifdef RIPPLE_MON_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] cnt;
        logic       track;
        logic [7:0] wrap;
        logic       ev_valid;
        logic [7:0] ev_value;
        logic       ovf;
        logic       err;
    } model_t;

    model_t m = '0;
    int     vectors = 0;
    int     miscompares = 0;
    bit     started = 0;

    // Next model state from the monitor's rules, using plain integer math.
    function automatic model_t model_next(input model_t cur, input logic [3:0] qin,
                                          input logic rdy);
        model_t n = cur;
        int p;
        int v;
        int w;
        bit wrapped = 0;
        n.h1 = qin;
        n.h2 = cur.h1;
        if (cur.h1 == cur.h2) begin
            v = int'(cur.h2);
            p = int'(cur.cnt);
            if (!cur.track) begin
                n.track = 1'b1;
                n.cnt   = cur.h2;
            end else if (v != p) begin
                n.cnt = cur.h2;
                if (v == 0 && p == 15) begin
                    wrapped = 1;
                    w = (int'(cur.wrap) + 1) % 256;
                    n.wrap = 8'(w);
                    if (!cur.ev_valid || rdy) begin
                        n.ev_valid = 1'b1;
                        n.ev_value = 8'(w);
                    end else begin
                        n.ovf = 1'b1;
                    end
                end else if (v == 0) begin
                    n.wrap = 8'd0;
                end else if (v != p + 1) begin
                    n.err = 1'b1;
                end
            end
        end
        if (!wrapped && cur.ev_valid && rdy)
            n.ev_valid = 1'b0;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)
            m <= '0;
        else
            m <= model_next(m, q, evt_if.evt_ready);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("m.cnt_stable", int'(cnt_stable), int'(m.cnt));
            check("m.wrap_count", int'(wrap_count), int'(m.wrap));
            check("m.evt_valid", int'(evt_if.evt_valid), int'(m.ev_valid));
            check("m.evt_value", int'(evt_if.evt_value), int'(m.ev_value));
            check("m.evt_ovf", int'(evt_ovf), int'(m.ovf));
`ifdef RIPPLE_MON_ERR_EN
            check("m.err", int'(err), int'(m.err));
`endif
        end
    end

    task automatic put(input logic [3:0] v, input int n);
        q = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic count_up(input int from, input int upto);
        for (int i = from; i <= upto; i++)
            put(4'(i), 3);
    endtask

    initial begin
        q = 4'd0;
        reset = 1'b1;
        evt_if.evt_ready = 1'b0;
        #12;
        check("rst.cnt_stable", int'(cnt_stable), 0);
        check("rst.wrap_count", int'(wrap_count), 0);
        check("rst.evt_valid", int'(evt_if.evt_valid), 0);
        check("rst.evt_value", int'(evt_if.evt_value), 0);
        check("rst.evt_ovf", int'(evt_ovf), 0);
        check("rst.state", int'(dut.state), int'(MON_INIT));
        #5 reset = 1'b0;
        @(negedge clk);

        // First run: baseline, no event until 15->0.
        count_up(0, 15);
        check("run.cnt15", int'(cnt_stable), 15);
        check("run.no_evt", int'(evt_if.evt_valid), 0);
        check("run.state", int'(dut.state), int'(MON_TRACK));
        put(4'd0, 3);
        check("wrap1.count", int'(wrap_count), 1);
        check("wrap1.valid", int'(evt_if.evt_valid), 1);
        check("wrap1.value", int'(evt_if.evt_value), 1);
        evt_if.evt_ready = 1'b1;
        put(4'd0, 1);
        evt_if.evt_ready = 1'b0;
        check("accept1.valid", int'(evt_if.evt_valid), 0);

        // Glitch 7 -> 5 (one sample) -> 8.
        count_up(1, 7);
        put(4'd5, 1);
        put(4'd8, 3);
        check("glitch.cnt", int'(cnt_stable), 8);
`ifdef RIPPLE_MON_ERR_EN
        check("glitch.err", int'(err), 0);
`endif
        count_up(9, 15);
        put(4'd0, 3);
        check("wrap2.count", int'(wrap_count), 2);
        check("wrap2.value", int'(evt_if.evt_value), 2);
        evt_if.evt_ready = 1'b1;
        put(4'd0, 1);
        evt_if.evt_ready = 1'b0;

        // Restart at 9.
        count_up(1, 9);
        put(4'd0, 3);
        check("restart.count", int'(wrap_count), 0);
        check("restart.valid", int'(evt_if.evt_valid), 0);

        // Two wraps with no ready: second dropped.
        count_up(1, 15);
        put(4'd0, 3);
        count_up(1, 15);
        put(4'd0, 3);
        check("ovf.count", int'(wrap_count), 2);
        check("ovf.value", int'(evt_if.evt_value), 1);
        check("ovf.flag", int'(evt_ovf), 1);
        check("ovf.valid", int'(evt_if.evt_valid), 1);

        // Wrap coinciding with ready: refill, valid stays high.
        count_up(1, 15);
        put(4'd0, 2);
        evt_if.evt_ready = 1'b1;
        put(4'd0, 1);
        evt_if.evt_ready = 1'b0;
        check("coinc.valid", int'(evt_if.evt_valid), 1);
        check("coinc.value", int'(evt_if.evt_value), 3);
        check("coinc.count", int'(wrap_count), 3);

        // Skip 4 -> 6.
        count_up(1, 4);
        put(4'd6, 3);
        check("skip.cnt", int'(cnt_stable), 6);
`ifdef RIPPLE_MON_ERR_EN
        check("skip.err", int'(err), 1);
`endif
        put(4'd7, 3);
`ifdef RIPPLE_MON_ERR_EN
        check("skip.err_sticky", int'(err), 1);
`endif
        check("skip.pending", int'(evt_if.evt_valid), 1);

        // Reset with an event pending.
        q = 4'd0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("mrst.cnt_stable", int'(cnt_stable), 0);
        check("mrst.wrap_count", int'(wrap_count), 0);
        check("mrst.evt_valid", int'(evt_if.evt_valid), 0);
        check("mrst.evt_value", int'(evt_if.evt_value), 0);
        check("mrst.evt_ovf", int'(evt_ovf), 0);
        check("mrst.state", int'(dut.state), int'(MON_INIT));
`ifdef RIPPLE_MON_ERR_EN
        check("mrst.err", int'(err), 0);
`endif
        #2 reset = 1'b0;
        @(negedge clk);

        // 256 wraps, consumer always ready.
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            count_up(1, 15);
            put(4'd0, 3);
            if (i == 254)
                check("roll.count255", int'(wrap_count), 255);
        end
        check("roll.count", int'(wrap_count), 0);
        check("roll.valid", int'(evt_if.evt_valid), 1);
        check("roll.value", int'(evt_if.evt_value), 0);
        check("roll.ovf", int'(evt_ovf), 0);
        put(4'd0, 1);
        check("roll.accepted", int'(evt_if.evt_valid), 0);
        evt_if.evt_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
